// File: rtl/pim_pkg.sv
// Shared types and default widths for the PIM matrix-multiply sequencer.
package pim_pkg;
  typedef enum logic [2:0] {IDLE, RD_A, WT_A, RD_B, WT_B, WR, DONE} matmul_state_e;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MAX_DIM_DEF = 8;
endpackage

// File: rtl/pim_addr_gen.sv
// Element address generator: base + (row*dim + col) * BYTES, wrapping at ADDR_W bits.
module pim_addr_gen
  import pim_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = 4,
  parameter int BYTES  = 4
)(
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_row,
  input  logic [DIM_W-1:0]  i_col,
  input  logic [DIM_W-1:0]  i_dim,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] w_idx;

  assign w_idx  = ADDR_W'(i_row) * ADDR_W'(i_dim) + ADDR_W'(i_col);
  assign o_addr = i_base + w_idx * ADDR_W'(BYTES);
endmodule

// File: rtl/pim_matmul_seq.sv
// Sequencer computing C = A x B over a single-outstanding memory request/response bus,
// i/j/k loop order with a runtime dimension and optional transposed B.
module pim_matmul_seq
  import pim_pkg::*;
#(
  parameter int  ADDR_W  = ADDR_W_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  MAX_DIM = MAX_DIM_DEF,
  localparam int DIM_W   = $clog2(MAX_DIM + 1)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DIM_W-1:0]  dim,
  input  logic              b_trans,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycles,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);
  localparam int BYTES = DATA_W / 8;

  matmul_state_e            r_state;
  logic [1:0]               r_rst_sync;
  logic                     w_rst_n;
  logic [ADDR_W-1:0]        r_src1, r_src2, r_dst;
  logic [DIM_W-1:0]         r_dim, r_i, r_j, r_k;
  logic                     r_b_trans;
  logic signed [DATA_W-1:0] r_a, r_acc;
  logic                     r_busy, r_done, r_err, r_req_valid;
  logic [31:0]              r_cycles;

  logic signed [DATA_W-1:0] w_rdata, w_prod, w_acc_base;
  logic [ADDR_W-1:0]        w_base, w_addr;
  logic [DIM_W-1:0]         w_row, w_col, w_last;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_base = '0;
    w_row  = '0;
    w_col  = '0;
    case (r_state)
      RD_A: begin w_base = r_src1; w_row = r_i; w_col = r_k; end
      RD_B: begin
        w_base = r_src2;
        w_row  = r_b_trans ? r_j : r_k;
        w_col  = r_b_trans ? r_k : r_j;
      end
      WR:   begin w_base = r_dst; w_row = r_i; w_col = r_j; end
      default: ;
    endcase
  end

  pim_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .BYTES(BYTES)) u_addr_gen (
    .i_base (w_base),
    .i_row  (w_row),
    .i_col  (w_col),
    .i_dim  (r_dim),
    .o_addr (w_addr)
  );

  assign w_rdata    = mem_rsp_rdata;
  assign w_prod     = r_a * w_rdata;
  assign w_acc_base = (r_k == '0) ? '0 : r_acc;
  assign w_last     = r_dim - DIM_W'(1);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dst       <= '0;
      r_dim       <= '0;
      r_b_trans   <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_req_valid <= 1'b0;
      r_cycles    <= '0;
    end else begin
      if (r_state != IDLE) r_cycles <= sat_inc(r_cycles);
      case (r_state)
        IDLE: if (start) begin
          r_src1    <= src1_addr;
          r_src2    <= src2_addr;
          r_dst     <= dst_addr;
          r_dim     <= dim;
          r_b_trans <= b_trans;
          r_i       <= '0;
          r_j       <= '0;
          r_k       <= '0;
          // The acceptance cycle itself is part of the reported latency.
          r_cycles  <= 32'd1;
          if (dim == '0 || int'(dim) > MAX_DIM) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state     <= RD_A;
            r_busy      <= 1'b1;
            r_req_valid <= 1'b1;
          end
        end
        RD_A: if (mem_req_ready) begin
          r_req_valid <= 1'b0;
          r_state     <= WT_A;
        end
        WT_A: if (mem_rsp_valid) begin
          r_a         <= w_rdata;
          r_req_valid <= 1'b1;
          r_state     <= RD_B;
        end
        RD_B: if (mem_req_ready) begin
          r_req_valid <= 1'b0;
          r_state     <= WT_B;
        end
        WT_B: if (mem_rsp_valid) begin
          r_acc       <= w_acc_base + w_prod;
          r_req_valid <= 1'b1;
          if (r_k != w_last) begin
            r_k     <= r_k + DIM_W'(1);
            r_state <= RD_A;
          end else begin
            r_state <= WR;
          end
        end
        WR: if (mem_req_ready) begin
          r_k <= '0;
          if (r_j != w_last) begin
            r_j     <= r_j + DIM_W'(1);
            r_state <= RD_A;
          end else begin
            r_j <= '0;
            if (r_i != w_last) begin
              r_i     <= r_i + DIM_W'(1);
              r_state <= RD_A;
            end else begin
              r_req_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_err       <= 1'b0;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign cycles        = r_cycles;
  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = (r_state == WR);
  assign mem_req_addr  = w_addr;
  assign mem_req_wdata = (r_state == WR) ? r_acc : '0;
endmodule
